uart_rx_param: RTL and testbench

Parametrised UART receiver and the next generation of the board's serial input path. It accepts an asynchronous RxD line, oversamples it with an internal baud-tick divider, and supports configurable data width, parity and stop bits. It delivers each frame through a valid/ready holding register with parity, framing and overrun status. It sits between the board's serial pin and any consumer (command decoder, FIFO, LED/7-seg debug logic) on the single system clock.

---
 rtl/uart_rx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting; otherwise each bit is sampled once.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_PRE     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC     = TW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [TW-1:0] T_DEC     = TW'(OVERSAMPLE / 2);
`endif
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state, state_n;
    logic                 rxd_m, rxd_s, rxd_d;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tcnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, stop_bad;
    logic                 start_edge, tick, at_dec, at_wrap, bit_val;
    logic                 complete, load;

    // Input synchroniser plus one-cycle delay for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= RxD_in;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign start_edge = (state == IDLE) && rxd_d && !rxd_s;
    assign tick       = (div_cnt == DIV_LAST);
    assign at_dec     = tick && (tcnt == T_DEC);
    assign at_wrap    = tick && (tcnt == T_LAST);
    assign load       = complete && (!rx_valid || rx_ready);
    assign busy       = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
    logic s_pre, s_mid;

    always_ff @(posedge clk) begin
        if (tick && tcnt == T_PRE) s_pre <= rxd_s;
        if (tick && tcnt == T_MID) s_mid <= rxd_s;
    end

    assign bit_val = maj3(s_pre, s_mid, rxd_s);
`else
    assign bit_val = rxd_s;
`endif

    // Tick divider and tick/bit counters, realigned on every start edge
    always_ff @(posedge clk) begin
        if (rst || start_edge || tick) div_cnt <= '0;
        else                           div_cnt <= div_cnt + 1'b1;

        if (rst || start_edge)           tcnt <= '0;
        else if (tick && state != IDLE)  tcnt <= tcnt + 1'b1;

        if (rst || start_edge) begin
            bit_cnt <= '0;
        end else if (at_wrap) begin
            if ((state == DATA && bit_cnt == DATA_LAST) || state == PAR)
                bit_cnt <= '0;
            else if (state == DATA || state == STOP)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        case (state)
            IDLE:      if (start_edge) state_n = START;
            START: begin
                if (at_dec && bit_val) state_n = IDLE;
                else if (at_wrap)      state_n = DATA;
            end
            DATA:      if (at_wrap && bit_cnt == DATA_LAST)
                           state_n = (PARITY != 0) ? PAR : STOP;
            PAR:       if (at_wrap) state_n = STOP;
            STOP: begin
                if (at_dec && bit_cnt == STOP_LAST) begin
                    complete = 1'b1;
                    state_n  = bit_val ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: if (rxd_s) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Frame assembly: data shift register and per-frame error flags
    always_ff @(posedge clk) begin
        if (at_dec && state == DATA)
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};

        if (rst || start_edge)
            par_bad <= 1'b0;
        else if (at_dec && state == PAR)
            par_bad <= ((^shreg) ^ bit_val) != PAR_ODD;

        if (rst || start_edge)
            stop_bad <= 1'b0;
        else if (at_dec && state == STOP && !bit_val)
            stop_bad <= 1'b1;
    end

    // Holding register; a completion in the transfer cycle keeps rx_valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= complete && !load;
            if (load) begin
                rx_data    <= shreg;
                parity_err <= (PARITY != 0) && par_bad;
                frame_err  <= stop_bad || !bit_val;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance (a_*) and a 7E1 instance (b_*), 32 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CF  = 3200000;
    localparam int BR  = 100000;
    localparam int OS  = 16;
    localparam int BIT = 32;
`ifdef UART_RX_MAJORITY_EN
    localparam int EXP_LAT = 311;
`else
    localparam int EXP_LAT = 309;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_rxd = 1'b1, b_rxd = 1'b1;
    logic       a_ready = 1'b1, b_ready = 1'b1;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_busy;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         a_cnt = 0, a_vcycles = 0, a_ovr_cnt = 0, a_rise_cyc = 0;
    logic       a_vprev = 1'b0;
    logic [7:0] a_last_data = '0;
    logic       a_last_perr = 1'b0, a_last_ferr = 1'b0;
    int         b_cnt = 0;
    logic [6:0] b_last_data = '0;
    logic       b_last_perr = 1'b0, b_last_ferr = 1'b0;

    uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .RxD_in(a_rxd), .rx_data(a_data), .rx_valid(a_valid),
        .rx_ready(a_ready), .parity_err(a_perr), .frame_err(a_ferr),
        .overrun(a_ovr), .busy(a_busy));

    uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .RxD_in(b_rxd), .rx_data(b_data), .rx_valid(b_valid),
        .rx_ready(b_ready), .parity_err(b_perr), .frame_err(b_ferr),
        .overrun(b_ovr), .busy(b_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word capture on the falling edge
    always @(negedge clk) begin
        if (a_valid && !a_vprev) a_rise_cyc = cyc;
        a_vprev = a_valid;
        if (a_valid) a_vcycles++;
        if (a_ovr) a_ovr_cnt++;
        if (a_valid && a_ready) begin
            a_cnt++;
            a_last_data = a_data;
            a_last_perr = a_perr;
            a_last_ferr = a_ferr;
        end
        if (b_valid && b_ready) begin
            b_cnt++;
            b_last_data = b_data;
            b_last_perr = b_perr;
            b_last_ferr = b_ferr;
        end
    end

    task automatic drive(input logic sel, input logic v);
        if (sel) b_rxd = v;
        else     a_rxd = v;
    endtask

    // par < 0 means no parity bit; glitch_bit pulls that data bit low for 2 cycles near mid-bit
    task automatic send_frame(input logic sel, input logic [8:0] data, input int nbits,
                              input int par, input int glitch_bit);
        drive(sel, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            drive(sel, data[k]);
            if (k == glitch_bit) begin
                repeat (17) @(negedge clk);
                drive(sel, 1'b0);
                repeat (2) @(negedge clk);
                drive(sel, data[k]);
                repeat (13) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            repeat (BIT) @(negedge clk);
        end
        drive(sel, 1'b1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 0", a_data); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", a_valid); end
        checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", a_perr); end
        checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", a_ferr); end
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", a_ovr); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", b_valid); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b expected 0", b_busy); end
    endtask

    task automatic test_8n1;
        int c0, n0, v0;
        a_ready = 1'b1;
        repeat (4) @(negedge clk);
        n0 = a_cnt; v0 = a_vcycles; c0 = cyc;
        send_frame(1'b0, 9'h0A5, 8, -1, -1);
        repeat (8) @(negedge clk);
        checks++; if (a_cnt - n0 !== 1) begin errors++; $display("FAIL 8n1_count: got %0d expected 1", a_cnt - n0); end
        checks++; if (a_last_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %0h expected a5", a_last_data); end
        checks++; if (a_last_perr !== 1'b0) begin errors++; $display("FAIL 8n1_parity_err: got %b expected 0", a_last_perr); end
        checks++; if (a_last_ferr !== 1'b0) begin errors++; $display("FAIL 8n1_frame_err: got %b expected 0", a_last_ferr); end
        checks++; if (a_vcycles - v0 !== 1) begin errors++; $display("FAIL 8n1_valid_width: got %0d expected 1", a_vcycles - v0); end
        checks++; if (a_rise_cyc - c0 !== EXP_LAT) begin errors++; $display("FAIL 8n1_latency: got %0d expected %0d", a_rise_cyc - c0, EXP_LAT); end
    endtask

    task automatic test_parity;
        int n0;
        n0 = b_cnt;
        send_frame(1'b1, 9'h035, 7, 0, -1);
        repeat (8) @(negedge clk);
        checks++; if (b_cnt - n0 !== 1) begin errors++; $display("FAIL par_good_count: got %0d expected 1", b_cnt - n0); end
        checks++; if (b_last_data !== 7'h35) begin errors++; $display("FAIL par_good_data: got %0h expected 35", b_last_data); end
        checks++; if (b_last_perr !== 1'b0) begin errors++; $display("FAIL par_good_parity_err: got %b expected 0", b_last_perr); end
        checks++; if (b_last_ferr !== 1'b0) begin errors++; $display("FAIL par_good_frame_err: got %b expected 0", b_last_ferr); end
        n0 = b_cnt;
        send_frame(1'b1, 9'h035, 7, 1, -1);
        repeat (8) @(negedge clk);
        checks++; if (b_cnt - n0 !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", b_cnt - n0); end
        checks++; if (b_last_data !== 7'h35) begin errors++; $display("FAIL par_bad_data: got %0h expected 35", b_last_data); end
        checks++; if (b_last_perr !== 1'b1) begin errors++; $display("FAIL par_bad_parity_err: got %b expected 1", b_last_perr); end
        checks++; if (b_last_ferr !== 1'b0) begin errors++; $display("FAIL par_bad_frame_err: got %b expected 0", b_last_ferr); end
    endtask

    task automatic test_break;
        int n0;
        a_ready = 1'b1;
        n0 = a_cnt;
        drive(1'b0, 1'b0);
        repeat (20 * BIT - 10) @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL break_busy_wait_high: got %b expected 1", a_busy); end
        repeat (10) @(negedge clk);
        drive(1'b0, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (a_cnt - n0 !== 1) begin errors++; $display("FAIL break_count: got %0d expected 1", a_cnt - n0); end
        checks++; if (a_last_data !== 8'h00) begin errors++; $display("FAIL break_data: got %0h expected 0", a_last_data); end
        checks++; if (a_last_ferr !== 1'b1) begin errors++; $display("FAIL break_frame_err: got %b expected 1", a_last_ferr); end
        send_frame(1'b0, 9'h05A, 8, -1, -1);
        repeat (8) @(negedge clk);
        checks++; if (a_cnt - n0 !== 2) begin errors++; $display("FAIL after_break_count: got %0d expected 2", a_cnt - n0); end
        checks++; if (a_last_data !== 8'h5A) begin errors++; $display("FAIL after_break_data: got %0h expected 5a", a_last_data); end
        checks++; if (a_last_ferr !== 1'b0) begin errors++; $display("FAIL after_break_frame_err: got %b expected 0", a_last_ferr); end
    endtask

    task automatic test_overrun;
        int o0;
        a_ready = 1'b0;
        o0 = a_ovr_cnt;
        send_frame(1'b0, 9'h011, 8, -1, -1);
        send_frame(1'b0, 9'h022, 8, -1, -1);
        repeat (8) @(negedge clk);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", a_valid); end
        checks++; if (a_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %0h expected 11", a_data); end
        checks++; if (a_ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", a_ovr_cnt - o0); end
        a_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b expected 0", a_valid); end
    endtask

    task automatic test_false_start;
        int n0;
        a_ready = 1'b1;
        repeat (4) @(negedge clk);
        n0 = a_cnt;
        drive(1'b0, 1'b0);
        repeat (8) @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_rise: got %b expected 1", a_busy); end
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1);
        repeat (BIT - 10) @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_fall: got %b expected 0", a_busy); end
        repeat (2 * BIT) @(negedge clk);
        checks++; if (a_cnt - n0 !== 0) begin errors++; $display("FAIL false_start_words: got %0d expected 0", a_cnt - n0); end
    endtask

    task automatic test_reset_midframe;
        int n0;
        a_ready = 1'b0;
        send_frame(1'b0, 9'h077, 8, -1, -1);
        checks++; if (a_data !== 8'h77) begin errors++; $display("FAIL pre_reset_data: got %0h expected 77", a_data); end
        drive(1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        drive(1'b0, 1'b1);
        repeat (3 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", a_valid); end
        checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %0h expected 0", a_data); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", a_busy); end
        checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", a_ferr); end
        a_ready = 1'b1;
        n0 = a_cnt;
        repeat (6 * BIT) @(negedge clk);
        checks++; if (a_cnt - n0 !== 0) begin errors++; $display("FAIL midrst_no_word: got %0d expected 0", a_cnt - n0); end
        send_frame(1'b0, 9'h03C, 8, -1, -1);
        repeat (8) @(negedge clk);
        checks++; if (a_cnt - n0 !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", a_cnt - n0); end
        checks++; if (a_last_data !== 8'h3C) begin errors++; $display("FAIL midrst_next_data: got %0h expected 3c", a_last_data); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_glitch;
        int n0;
        a_ready = 1'b1;
        n0 = a_cnt;
        send_frame(1'b0, 9'h03C, 8, -1, 2);
        repeat (8) @(negedge clk);
        checks++; if (a_cnt - n0 !== 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", a_cnt - n0); end
        checks++; if (a_last_data !== 8'h3C) begin errors++; $display("FAIL glitch_data: got %0h expected 3c", a_last_data); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_break();
        test_overrun();
        test_false_start();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        test_glitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
